// File: rtl/wave_scheduler_if.sv
// Handshake and control bundle between the wave scheduler, dispatcher,
// fetch stage and PC block.
interface wave_scheduler_if #(
  parameter int WAVES_PER_SIMD = 5,
  localparam int CTX_W = $clog2(WAVES_PER_SIMD)
);
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic             issue_ready;
  logic             wave_done;
  logic [CTX_W-1:0] active_context;
  logic             active_valid;
  logic             dispatch_new_wave;
  logic             update_pc;
  logic             busy;
  logic             full;

  modport master (
    input  dispatch_valid,
    input  issue_ready,
    input  wave_done,
    output dispatch_ready,
    output active_context,
    output active_valid,
    output dispatch_new_wave,
    output update_pc,
    output busy,
    output full
  );

  modport slave (
    output dispatch_valid,
    output issue_ready,
    output wave_done,
    input  dispatch_ready,
    input  active_context,
    input  active_valid,
    input  dispatch_new_wave,
    input  update_pc,
    input  busy,
    input  full
  );
endinterface

// File: rtl/wave_scheduler.sv
// Per-SIMD round-robin wave scheduler driving the PC block and fetch valid.
// Optional WAVE_SCHED_STATS_EN adds switch_count, counting LOAD cycles.
module wave_scheduler #(
  parameter int WAVES_PER_SIMD = 5,
  parameter int QUANTUM = 4,
  localparam int CTX_W = $clog2(WAVES_PER_SIMD)
) (
  input logic clk,
  input logic rst,
  wave_scheduler_if.master bus
`ifdef WAVE_SCHED_STATS_EN
  ,
  output logic [15:0] switch_count
`endif
);
  localparam int W = WAVES_PER_SIMD;
  localparam int QCW = $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    LOAD,
    RUN
  } state_t;

  state_t           state, state_nx;
  logic [W-1:0]     valid_mask, mask_nx;
  logic [QCW-1:0]   qcnt, qcnt_nx;
  logic             pend, pend_nx;
  logic [CTX_W-1:0] ctx, ctx_nx;
  logic [CTX_W-1:0] free_idx, rot_idx;
  logic             busy, full;

  assign busy = |valid_mask;
  assign full = &valid_mask;
  assign bus.busy = busy;
  assign bus.full = full;
  assign bus.active_context = ctx;

  always_comb begin : find_free
    free_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!valid_mask[CTX_W'(i)]) free_idx = CTX_W'(i);
    end
  end

  // Current slot is probed last so a lone wave reselects itself.
  always_comb begin : find_next
    int k;
    logic hit;
    rot_idx = ctx;
    hit = 1'b0;
    k = 0;
    for (int i = 1; i <= W; i++) begin
      k = int'(ctx) + i;
      if (k >= W) k = k - W;
      if (!hit && valid_mask[CTX_W'(k)]) begin
        rot_idx = CTX_W'(k);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    mask_nx = valid_mask;
    qcnt_nx = qcnt;
    pend_nx = pend;
    ctx_nx = ctx;
    bus.active_valid = 1'b0;
    bus.dispatch_ready = 1'b0;
    bus.dispatch_new_wave = 1'b0;
    bus.update_pc = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dispatch_valid) state_nx = SWITCH;
      end
      SWITCH: begin
        qcnt_nx = '0;
        if (bus.dispatch_valid && !full) begin
          ctx_nx = free_idx;
          pend_nx = 1'b1;
          state_nx = LOAD;
        end else if (busy) begin
          ctx_nx = rot_idx;
          state_nx = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        bus.dispatch_ready = pend;
        bus.dispatch_new_wave = pend;
        if (pend) begin
          mask_nx[ctx] = 1'b1;
          pend_nx = 1'b0;
        end
        state_nx = RUN;
      end
      RUN: begin
        bus.active_valid = 1'b1;
        if (bus.wave_done) begin
          mask_nx[ctx] = 1'b0;
          state_nx = SWITCH;
        end else if (bus.issue_ready) begin
          bus.update_pc = 1'b1;
          qcnt_nx = qcnt + QCW'(1);
          if (qcnt == QCW'(QUANTUM - 1)) state_nx = SWITCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid_mask <= '0;
      qcnt <= '0;
      pend <= 1'b0;
      ctx <= '0;
    end else begin
      state <= state_nx;
      valid_mask <= mask_nx;
      qcnt <= qcnt_nx;
      pend <= pend_nx;
      ctx <= ctx_nx;
    end
  end

`ifdef WAVE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) switch_count <= '0;
    else if (state == LOAD) switch_count <= switch_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_wave_scheduler.sv
// Randomized bench for wave_scheduler against a slot-occupancy reference
// model that tracks residency, quanta and the two-cycle switch gap.
module tb_wave_scheduler;
  localparam int W = 5;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_scheduler_if #(.WAVES_PER_SIMD(W)) bus ();
`ifdef WAVE_SCHED_STATS_EN
  logic [15:0] switch_count;
`endif

  wave_scheduler #(
    .WAVES_PER_SIMD(W),
    .QUANTUM(Q)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WAVE_SCHED_STATS_EN
    ,
    .switch_count(switch_count)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: occupancy, who runs, how much of the quantum is used,
  // and how many bubble cycles remain before the chosen wave runs.
  bit occ[W];
  int cur, gap, used, pend, loads;
  bit idle, mvalid;
  bit dv_hold;

  function automatic int n_occ();
    int n = 0;
    for (int i = 0; i < W; i++) n += occ[i];
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < W; i++) if (!occ[i]) return i;
    return -1;
  endfunction

  function automatic int next_rot();
    for (int i = 1; i <= W; i++) if (occ[(cur + i) % W]) return (cur + i) % W;
    return cur;
  endfunction

  task automatic model_reset();
    foreach (occ[i]) occ[i] = 1'b0;
    cur = 0;
    gap = 0;
    used = 0;
    pend = -1;
    loads = 0;
    idle = 1'b1;
  endtask

  task automatic model_step(bit dv, bit ir, bit wd);
    if (idle) begin
      if (dv) begin
        idle = 1'b0;
        gap = 2;
      end
    end else if (gap == 2) begin
      if (dv && n_occ() < W) begin
        pend = lowest_free();
        cur = pend;
        gap = 1;
      end else if (n_occ() > 0) begin
        cur = next_rot();
        gap = 1;
      end else begin
        idle = 1'b1;
        gap = 0;
      end
    end else if (gap == 1) begin
      loads++;
      if (pend >= 0) occ[pend] = 1'b1;
      pend = -1;
      gap = 0;
      used = 0;
    end else begin
      if (wd) begin
        occ[cur] = 1'b0;
        gap = 2;
      end else if (ir) begin
        used++;
        if (used == Q) gap = 2;
      end
    end
  endtask

  task automatic run_cycle(bit r, bit ir, bit wd);
    bit e_av, e_dr, e_upd;
    @(posedge clk);
    #1;
    rst = r;
    bus.dispatch_valid = dv_hold;
    bus.issue_ready = ir;
    bus.wave_done = wd;
    #2;
    e_av = !idle && gap == 0;
    e_dr = !idle && gap == 1 && pend >= 0;
    e_upd = e_av && ir && !wd;
    if (mvalid) begin
      chk("active_context", 32'(bus.active_context), 32'(cur));
      chk("active_valid", 32'(bus.active_valid), 32'(e_av));
      chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(e_dr));
      chk("dispatch_new_wave", 32'(bus.dispatch_new_wave), 32'(e_dr));
      chk("update_pc", 32'(bus.update_pc), 32'(e_upd));
      chk("busy", 32'(bus.busy), 32'(n_occ() > 0));
      chk("full", 32'(bus.full), 32'(n_occ() == W));
`ifdef WAVE_SCHED_STATS_EN
      chk("switch_count", 32'(switch_count), 32'(loads % 65536));
`endif
    end
    if (dv_hold && e_dr) dv_hold = 1'b0;
    if (r) begin
      model_reset();
      mvalid = 1'b1;
    end else begin
      model_step(bus.dispatch_valid, ir, wd);
    end
  endtask

  task automatic phase(int n, int pdv, int pir, int pwd);
    for (int c = 0; c < n; c++) begin
      if (!dv_hold && $urandom_range(99) < pdv) dv_hold = 1'b1;
      run_cycle($urandom_range(999) < 3,
                $urandom_range(99) < pir,
                $urandom_range(99) < pwd);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dispatch_valid = 1'b0;
    bus.issue_ready = 1'b0;
    bus.wave_done = 1'b0;
    mvalid = 1'b0;
    dv_hold = 1'b0;
    model_reset();
    run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0);
    // First dispatch from idle, then two waves sharing the SIMD.
    dv_hold = 1'b1;
    for (int c = 0; c < 6; c++) run_cycle(1'b0, 1'b1, 1'b0);
    dv_hold = 1'b1;
    for (int c = 0; c < 24; c++) run_cycle(1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b1, 1'b0);
    phase(2000, 40, 80, 2);
    phase(1500, 5, 90, 15);
    phase(2000, 25, 50, 6);
    phase(1500, 60, 100, 1);
    phase(800, 0, 70, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
